// File: rtl/i2c_sync_filt.sv
// Purpose : I2C pad conditioner: synchronises SCL/SDA into clk, rejects glitches
//           shorter than FILT_LEN cycles, derives SCL edges, START/STOP pulses
//           and a bus-busy flag.
// Latency : pad level first sampled at edge k -> scl_o/sda_o change at edge
//           k+STAGES+FILT_LEN-1; edge/START/STOP pulses are combinational from
//           that point; bus_busy follows the detect pulse by one cycle.
// Backpr. : none; every pulse is valid for exactly one cycle and is lost if the
//           consumer does not sample it in that cycle.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   scl_i      raw SCL from pad (asynchronous)
//   sda_i      raw SDA from pad (asynchronous)
//   scl_o      synchronised, filtered SCL level
//   sda_o      synchronised, filtered SDA level
//   scl_rise   1-cycle pulse, first cycle of scl_o==1 after 0
//   scl_fall   1-cycle pulse, first cycle of scl_o==0 after 1
//   start_det  1-cycle pulse on START or repeated START
//   stop_det   1-cycle pulse on STOP
//   bus_busy   high between START and STOP
module i2c_sync_filt #(
    parameter int STAGES   = 2,
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy
);

    // FILT_LEN==1 needs no counter at all; keep a 1-bit one so the width is legal.
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    if (STAGES < 2) begin : g_bad_stages
        $error("i2c_sync_filt: STAGES must be >= 2");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
        $error("i2c_sync_filt: FILT_LEN must be >= 1");
    end

    // Line 0 = SCL, line 1 = SDA.
    logic [1:0] pad_w;
    logic [1:0] filt_w;

    assign pad_w = {sda_i, scl_i};

    for (genvar l = 0; l < 2; l++) begin : g_line
        (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
        logic          sync_w;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          lvl_q;
        logic          lvl_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '1;
            end else begin
                sync_q <= {sync_q[STAGES-2:0], pad_w[l]};
            end
        end

        assign sync_w = sync_q[STAGES-1];

        // The counter only runs while the synced level disagrees with the
        // accepted level; any return to agreement throws the count away, so a
        // new level is taken only after FILT_LEN consecutive disagreeing cycles.
        always_comb begin
            lvl_d = lvl_q;
            cnt_d = '0;
            if (sync_w != lvl_q) begin
                if (cnt_q == CNT_MAX) begin
                    lvl_d = sync_w;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                lvl_q <= 1'b1;
                cnt_q <= '0;
            end else begin
                lvl_q <= lvl_d;
                cnt_q <= cnt_d;
            end
        end

        assign filt_w[l] = lvl_q;
    end

    logic scl_dly_q;
    logic sda_dly_q;
    logic busy_q;
    logic busy_d;

    assign scl_o = filt_w[0];
    assign sda_o = filt_w[1];

    assign scl_rise  =  filt_w[0] & ~scl_dly_q;
    assign scl_fall  = ~filt_w[0] &  scl_dly_q;
    // SCL must be high in both the current and previous cycle, so an SDA edge
    // coincident with an SCL edge is never a bus condition; START and STOP need
    // opposite SDA transitions and so cannot fire together.
    assign start_det =  filt_w[0] & scl_dly_q &  sda_dly_q & ~filt_w[1];
    assign stop_det  =  filt_w[0] & scl_dly_q & ~sda_dly_q &  filt_w[1];

    always_comb begin
        busy_d = busy_q;
        if (stop_det) begin
            busy_d = 1'b0;
        end else if (start_det) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_dly_q <= 1'b1;
            sda_dly_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            scl_dly_q <= filt_w[0];
            sda_dly_q <= filt_w[1];
            busy_q    <= busy_d;
        end
    end

    assign bus_busy = busy_q;

endmodule

// File: tb/tb_i2c_sync_filt.sv
// Bench for i2c_sync_filt: instance A (STAGES=2, FILT_LEN=4) and
// instance B (STAGES=3, FILT_LEN=1) share the pads and the reset.
module tb_i2c_sync_filt;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_i = 1'b1;
    logic sda_i = 1'b1;

    logic a_scl_o, a_sda_o, a_scl_rise, a_scl_fall, a_start_det, a_stop_det, a_bus_busy;
    logic b_scl_o, b_sda_o, b_scl_rise, b_scl_fall, b_start_det, b_stop_det, b_bus_busy;

    always #5 clk = ~clk;

    i2c_sync_filt #(.STAGES(2), .FILT_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i),
        .scl_o(a_scl_o), .sda_o(a_sda_o), .scl_rise(a_scl_rise), .scl_fall(a_scl_fall),
        .start_det(a_start_det), .stop_det(a_stop_det), .bus_busy(a_bus_busy)
    );

    i2c_sync_filt #(.STAGES(3), .FILT_LEN(1)) dut_b (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i),
        .scl_o(b_scl_o), .sda_o(b_sda_o), .scl_rise(b_scl_rise), .scl_fall(b_scl_fall),
        .start_det(b_start_det), .stop_det(b_stop_det), .bus_busy(b_bus_busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pad history: bit j of h_* is the pad level sampled j edges ago.  A line's
    // accepted level becomes v once the synchronised samples of the last
    // FILT_LEN edges (pad history STAGES..STAGES+FILT_LEN-1) all read v.
    logic [15:0] h_scl [2];
    logic [15:0] h_sda [2];
    bit m_scl [2];
    bit m_sda [2];
    bit p_scl [2];
    bit p_sda [2];
    bit m_busy [2];
    bit was_start [2];
    bit was_stop [2];

    function automatic int stg(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int flen(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic bit settle(input logic [15:0] h, input int st, input int fl, input bit cur);
        bit v;
        v = h[st];
        for (int j = st; j < st + fl; j++) begin
            if (h[j] != v) return cur;
        end
        return v;
    endfunction

    function automatic bit ev_start(input int i);
        return m_scl[i] && p_scl[i] && p_sda[i] && !m_sda[i];
    endfunction

    function automatic bit ev_stop(input int i);
        return m_scl[i] && p_scl[i] && !p_sda[i] && m_sda[i];
    endfunction

    function automatic logic [6:0] expect_vec(input int i);
        return {m_scl[i], m_sda[i], m_scl[i] && !p_scl[i], !m_scl[i] && p_scl[i],
                ev_start(i), ev_stop(i), m_busy[i]};
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                h_scl[i]  = '1;
                h_sda[i]  = '1;
                m_scl[i]  = 1'b1;
                m_sda[i]  = 1'b1;
                p_scl[i]  = 1'b1;
                p_sda[i]  = 1'b1;
                m_busy[i] = 1'b0;
            end else begin
                was_start[i] = ev_start(i);
                was_stop[i]  = ev_stop(i);
                if (was_stop[i]) m_busy[i] = 1'b0;
                else if (was_start[i]) m_busy[i] = 1'b1;
                p_scl[i] = m_scl[i];
                p_sda[i] = m_sda[i];
                h_scl[i] = {h_scl[i][14:0], scl_i};
                h_sda[i] = {h_sda[i][14:0], sda_i};
                m_scl[i] = settle(h_scl[i], stg(i), flen(i), m_scl[i]);
                m_sda[i] = settle(h_sda[i], stg(i), flen(i), m_sda[i]);
            end
        end
    end

    // ---------------- per-cycle compare + event counters ----------------
    int a_rise_n, a_fall_n, a_start_n, a_stop_n, a_sdalo_n, a_scllo_n, a_busy_n;
    int b_rise_n, b_fall_n, b_scllo_n;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_outputs", {25'd0, a_scl_o, a_sda_o, a_scl_rise, a_scl_fall,
                              a_start_det, a_stop_det, a_bus_busy}, {25'd0, expect_vec(0)});
            chk("b_outputs", {25'd0, b_scl_o, b_sda_o, b_scl_rise, b_scl_fall,
                              b_start_det, b_stop_det, b_bus_busy}, {25'd0, expect_vec(1)});
            a_rise_n  += int'(a_scl_rise);
            a_fall_n  += int'(a_scl_fall);
            a_start_n += int'(a_start_det);
            a_stop_n  += int'(a_stop_det);
            a_sdalo_n += int'(!a_sda_o);
            a_scllo_n += int'(!a_scl_o);
            a_busy_n  += int'(a_bus_busy);
            b_rise_n  += int'(b_scl_rise);
            b_fall_n  += int'(b_scl_fall);
            b_scllo_n += int'(!b_scl_o);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr();
        a_rise_n = 0; a_fall_n = 0; a_start_n = 0; a_stop_n = 0;
        a_sdalo_n = 0; a_scllo_n = 0; a_busy_n = 0;
        b_rise_n = 0; b_fall_n = 0; b_scllo_n = 0;
    endtask

    task automatic wait_a_sda_low(input int k, output int lat);
        int n;
        n = 0;
        while (a_sda_o !== 1'b0 && n < 40) begin
            step(1);
            n++;
        end
        lat = (a_sda_o === 1'b0) ? cyc - k : -1;
    endtask

    initial begin
        int k;
        int lat;
        int n;
        clr();
        rst = 1'b1;
        @(posedge clk);
        #1 chk_on = 1'b1;
        step(3);

        // 1. idle after reset
        rst = 1'b0;
        clr();
        step(20);
        chk("t1_pulses", a_rise_n + a_fall_n + a_start_n + a_stop_n, 0);
        chk("t1_busy_cycles", a_busy_n, 0);
        chk("t1_low_cycles", a_sdalo_n + a_scllo_n, 0);

        // 2. 3-cycle SDA glitch rejected, 4-cycle low accepted as START
        clr();
        sda_i = 1'b0;
        step(3);
        sda_i = 1'b1;
        step(12);
        chk("t2_glitch_sda_low", a_sdalo_n, 0);
        chk("t2_glitch_start", a_start_n, 0);
        k = cyc + 1;
        sda_i = 1'b0;
        wait_a_sda_low(k, lat);
        chk("t2_latency", lat, 5);
        chk("t2_start_pulse", a_start_det, 1);
        chk("t2_busy_same", a_bus_busy, 0);
        step(1);
        chk("t2_busy_next", a_bus_busy, 1);
        chk("t2_start_width", a_start_det, 0);
        step(20);
        sda_i = 1'b1;
        step(20);

        // 3. byte frame
        clr();
        sda_i = 1'b0;
        step(20);
        for (int b = 0; b < 9; b++) begin
            scl_i = 1'b0;
            step(10);
            sda_i = 1'($urandom_range(0, 1));
            step(10);
            scl_i = 1'b1;
            step(20);
        end
        scl_i = 1'b0;
        step(10);
        sda_i = 1'b0;
        step(10);
        chk("t3_rise", a_rise_n, 9);
        chk("t3_fall", a_fall_n, 10);
        chk("t3_start", a_start_n, 1);
        chk("t3_stop_early", a_stop_n, 0);
        scl_i = 1'b1;
        step(20);
        sda_i = 1'b1;
        n = 0;
        while (a_stop_det !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        chk("t3_stop_seen", a_stop_det, 1);
        chk("t3_busy_at_stop", a_bus_busy, 1);
        step(1);
        chk("t3_busy_after_stop", a_bus_busy, 0);
        step(20);
        chk("t3_stop_total", a_stop_n, 1);

        // 4. simultaneous SCL/SDA edges are not bus conditions
        clr();
        scl_i = 1'b0;
        sda_i = 1'b0;
        step(20);
        chk("t4_fall", a_fall_n, 1);
        chk("t4_no_start", a_start_n, 0);
        scl_i = 1'b1;
        sda_i = 1'b1;
        step(20);
        chk("t4_rise", a_rise_n, 1);
        chk("t4_no_stop", a_stop_n, 0);

        // 5. reset mid-way through a qualifying SDA low while busy
        sda_i = 1'b0;
        step(20);
        scl_i = 1'b0;
        step(20);
        sda_i = 1'b1;
        step(20);
        scl_i = 1'b1;
        step(20);
        chk("t5_busy_before", a_bus_busy, 1);
        sda_i = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        chk("t5_reset_outputs", {25'd0, a_scl_o, a_sda_o, a_scl_rise, a_scl_fall,
                                 a_start_det, a_stop_det, a_bus_busy}, 32'h60);
        rst = 1'b0;
        k = cyc + 1;
        wait_a_sda_low(k, lat);
        chk("t5_latency_after_reset", lat, 5);
        step(20);
        sda_i = 1'b1;
        step(20);

        // 6. FILT_LEN=1, STAGES=3: single-cycle SCL pulse passes through
        clr();
        k = cyc + 1;
        scl_i = 1'b0;
        step(1);
        scl_i = 1'b1;
        n = 0;
        while (b_scl_o !== 1'b0 && n < 10) begin
            step(1);
            n++;
        end
        chk("t6_latency", (b_scl_o === 1'b0) ? cyc - k : -1, 3);
        step(1);
        chk("t6_width_end", b_scl_o, 1);
        step(10);
        chk("t6_b_fall", b_fall_n, 1);
        chk("t6_b_rise", b_rise_n, 1);
        chk("t6_b_low_cycles", b_scllo_n, 1);
        chk("t6_a_filtered", a_fall_n, 0);

        // 7. random pad activity, checked cycle by cycle against the model
        for (int r = 0; r < 120; r++) begin
            scl_i = 1'($urandom_range(0, 1));
            sda_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
            step($urandom_range(1, 7));
        end
        scl_i = 1'b1;
        sda_i = 1'b1;
        step(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
